// File: rtl/fifo_arb_pkg.sv
// Shared defaults and index type for the round-robin FIFO drain arbiter.
package fifo_arb_pkg;

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned BURST_DEF   = 4;
  localparam int unsigned SRC_W       = $clog2(NUM_SRC_DEF);

  typedef logic [SRC_W-1:0] src_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set request at or after start_i, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned j;
      j = (32'(start_i) + i) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Drains several source FIFOs into one registered output stream, round-robin with
// bounded bursts per source.
module fifo_rr_drain
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST      = BURST_DEF,
  localparam int unsigned SrcW      = $clog2(NUM_SRC)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_SRC-1:0]                  src_empty,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  src_rdata,
  input  logic [NUM_SRC-1:0]                  src_en,
  output logic [NUM_SRC-1:0]                  src_rd,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [SrcW-1:0]                     out_src
);

  localparam int unsigned    CntW    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [SrcW-1:0] LastIdx = SrcW'(NUM_SRC - 1);
  localparam logic [CntW-1:0] BcntMax = CntW'(BURST - 1);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SrcW-1:0]       out_src_q, out_src_d;
  logic [SrcW-1:0]       cur_q, cur_d;
  logic [CntW-1:0]       bcnt_q, bcnt_d;
  logic                  bact_q, bact_d;

  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] pick_gnt;
  logic [NUM_SRC-1:0] cur_oh;
  logic [SrcW-1:0]    pick_idx;
  logic [SrcW-1:0]    start;
  logic [SrcW-1:0]    sel;
  logic               pick_any;
  logic               load;
  logic               cont;
  logic               fire;

  assign load   = ~out_valid_q | out_ready;
  assign cand   = ~src_empty & src_en;
  assign cont   = bact_q & cand[cur_q] & (bcnt_q != BcntMax);
  // Search starts just past the last grant so the current source is checked last.
  assign start  = (cur_q == LastIdx) ? '0 : cur_q + 1'b1;
  assign cur_oh = NUM_SRC'(1) << cur_q;
  assign fire   = reset_n & load & pick_any;
  assign sel    = cont ? cur_q : pick_idx;

  rr_pick #(
    .N (NUM_SRC),
    .W (SrcW)
  ) u_rr_pick (
    .req_i   (cand),
    .start_i (start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    src_rd = '0;
    if (fire) begin
      src_rd = cont ? cur_oh : pick_gnt;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    cur_d       = cur_q;
    bcnt_d      = bcnt_q;
    bact_d      = bact_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = src_rdata[sel];
      out_src_d   = sel;
      cur_d       = sel;
      bact_d      = 1'b1;
      bcnt_d      = cont ? bcnt_q + 1'b1 : '0;
    end else if (load) begin
      out_valid_d = 1'b0;
      bact_d      = 1'b0;
      bcnt_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      cur_q       <= LastIdx;
      bcnt_q      <= '0;
      bact_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      cur_q       <= cur_d;
      bcnt_q      <= bcnt_d;
      bact_q      <= bact_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
